// File: rtl/alu_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_disp_pkg
// Description : Shared types and constants for the ALU result display block:
//               FSM state encoding, BCD geometry and active-low seven-segment
//               patterns (bit order {g,f,e,d,c,b,a}).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_disp_pkg;

    localparam int NUM_DIGITS = 3;
    localparam int BCD_W      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg
// Description : Combinational 4-bit BCD to active-low seven-segment decoder.
//               Codes above 9 decode to a blank digit.
// Ports       : bcd   [3:0] in  - BCD digit
//               seg_n [6:0] out - active-low segments {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg
    import alu_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_result_display.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_display
// Description : Captures an 8-bit ALU result on request, converts it to
//               3-digit BCD with a sequential double-dabble FSM (9 clocks
//               from load edge to bcd_out), and scans it onto a multiplexed
//               active-low 3-digit seven-segment display.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros of
//               the hundreds and tens digits.
// Ports       : clk, rst_n (async, active-low)
//               result_in[7:0], load       - capture request
//               busy, bcd_out[11:0], bcd_valid
//               seg_n[6:0] {g..a}, an_n[2:0] (an_n[0] = units)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  result_in,
    input  logic        load,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic        bcd_valid,
    output logic [6:0]  seg_n,
    output logic [2:0]  an_n
);

    localparam int         CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [3:0] BLANK_CODE = 4'hF;   // any code > 9 decodes blank

    state_t      state;
    state_t      state_nxt;
    // {scratch BCD (12), binary shift register (8)}
    logic [19:0] dd_q;
    logic [19:0] dd_nxt;
    logic [11:0] adj;
    logic [2:0]  iter_q;

    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       scan_idx;
    logic [3:0]       nib;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONVERT;
            CONVERT: if (iter_q == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // One double-dabble step: add-3 correction on every nibble >= 5, then
    // shift the whole scratch/shift pair left so the binary MSB enters units.
    always_comb begin
        adj = dd_q[19:8];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (adj[i*BCD_W +: BCD_W] >= 4'd5)
                adj[i*BCD_W +: BCD_W] = adj[i*BCD_W +: BCD_W] + 4'd3;
        end
        dd_nxt = {adj, dd_q[7:0]} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dd_q      <= '0;
            iter_q    <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        dd_q   <= {12'd0, result_in};
                        iter_q <= '0;
                    end
                end
                CONVERT: begin
                    dd_q   <= dd_nxt;
                    iter_q <= iter_q + 3'd1;
                end
                DONE: begin
                    // bcd_out only changes here, so the display never sees
                    // partially converted values.
                    bcd_out   <= dd_q[19:8];
                    bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- display scan ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
        end else if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign an_n = ~(3'b001 << scan_idx);

    always_comb begin
        nib = bcd_out[3:0];
        case (scan_idx)
            2'd1:    nib = bcd_out[7:4];
            2'd2:    nib = bcd_out[11:8];
            default: nib = bcd_out[3:0];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (scan_idx == 2'd2 && bcd_out[11:8] == 4'd0)
            nib = BLANK_CODE;
        if (scan_idx == 2'd1 && bcd_out[11:4] == 8'd0)
            nib = BLANK_CODE;
`else
        // Leading zeros are always shown; BLANK_CODE is only used above.
        if (1'b0) nib = BLANK_CODE;
`endif
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd   (nib),
        .seg_n (seg_n)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_result_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_display
// Description : Scoreboard bench for alu_result_display (REFRESH_DIV=4).
//               Stimulus pushes expected BCD and due edge into a queue; a
//               negedge monitor checks bcd_valid/bcd_out timing, busy and the
//               scanned display against a decimal-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_display;

    localparam int DIV = 4;

    typedef struct {
        logic [11:0] bcd;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  result_in = 8'd0;
    logic        load = 1'b0;
    logic        busy;
    logic [11:0] bcd_out;
    logic        bcd_valid;
    logic [6:0]  seg_n;
    logic [2:0]  an_n;

    int total = 0;
    int bad   = 0;

    exp_t        q[$];
    int          edge_cnt = 0;   // rising edges since reset release
    int          last_k   = 0;
    bit          has_k    = 1'b0;
    int          next_ok  = 0;
    logic [11:0] model_disp = 12'd0;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                  7'b0110000, 7'b0011001, 7'b0010010,
                                  7'b0000010, 7'b1111000, 7'b0000000,
                                  7'b0010000};

    alu_result_display #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .result_in (result_in),
        .load      (load),
        .busy      (busy),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .seg_n     (seg_n),
        .an_n      (an_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t edge=%0d)", name, act, exp, $time, edge_cnt);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            int          idx;
            logic [3:0]  d;
            logic [6:0]  exp_seg;
            logic [2:0]  exp_an;
            if (q.size() > 0 && q[0].due == edge_cnt) begin
                chk("bcd_valid_pulse", 32'(bcd_valid), 32'd1);
                chk("bcd_out", 32'(bcd_out), 32'(q[0].bcd));
                model_disp = q[0].bcd;
                void'(q.pop_front());
            end else begin
                chk("bcd_valid_idle", 32'(bcd_valid), 32'd0);
            end
            chk("busy", 32'(busy), 32'(has_k && edge_cnt >= last_k && edge_cnt <= last_k + 8));

            idx = (edge_cnt / DIV) % 3;
            exp_an = (idx == 0) ? 3'b110 : (idx == 1) ? 3'b101 : 3'b011;
            d = model_disp[idx*4 +: 4];
            exp_seg = seg_tab[d];
`ifdef LEADING_ZERO_BLANK_EN
            if (idx == 2 && model_disp[11:8] == 4'd0) exp_seg = 7'b1111111;
            if (idx == 1 && model_disp[11:4] == 8'd0) exp_seg = 7'b1111111;
`endif
            chk("an_n", 32'(an_n), 32'(exp_an));
            chk("seg_n", 32'(seg_n), 32'(exp_seg));
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_load(input int v);
        int k;
        @(negedge clk);
        result_in = 8'(v);
        load = 1'b1;
        k = edge_cnt + 1;
        if (k >= next_ok) begin
            q.push_back('{bcd: to_bcd(v), due: k + 9});
            last_k  = k;
            has_k   = 1'b1;
            next_ok = k + 10;
        end
        @(negedge clk);
        load = 1'b0;
        result_in = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            load = 1'b0;
            result_in = 8'($urandom);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_bcd_out", 32'(bcd_out), 32'd0);
        chk("rst_bcd_valid", 32'(bcd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_an_n", 32'(an_n), 32'b110);
        chk("rst_seg_n", 32'(seg_n), 32'b1000000);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values();
        #2 rst_n = 1'b1;

        // max value, then back-to-back load right after DONE
        do_load(255);
        idle(8);
        do_load(0);
        idle(10);
        do_load(100);
        idle(10);
        do_load(9);
        idle(10);
        // second load while busy is ignored
        do_load(42);
        idle(2);
        do_load(200);
        idle(12);
        // leading-zero case
        do_load(7);
        idle(20);
        // full scan pass over a three-digit value
        do_load(255);
        idle(24);

        // reset mid-conversion
        do_load(123);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_values();
        q.delete();
        has_k = 1'b0;
        next_ok = 0;
        model_disp = 12'd0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(12);

        // randomized loads, including loads while busy
        for (int n = 0; n < 60; n++) begin
            do_load(int'($urandom_range(0, 255)));
            idle(int'($urandom_range(0, 12)));
        end
        idle(20);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
Downstream consumer of the 8-bit ALU result produced by the operation-select mux. It captures a result on request and converts it from binary to 3-digit BCD with a sequential double-dabble FSM. It then drives a time-multiplexed, active-low 3-digit seven-segment display on the board.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit-scan step; legal range is 2 or more (1 kHz per digit at 100 MHz).
NUM_DIGITS, 3, number of display digits; fixed at 3, which covers 0..255.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
result_in  input  8  unsigned ALU result from the mux stage.
load  input  1  capture request; sampled on clk.
busy  output  1  high while a conversion is in progress.
bcd_out  output  12  {hundreds, tens, units}, 4 bits each; the last completed conversion.
bcd_valid  output  1  one-cycle pulse when bcd_out updates.
seg_n  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
an_n  output  3  active-low digit enables, one-hot; an_n[0] is units.

Behaviour:
- Reset (asynchronous, rst_n=0) drives:
  - state=IDLE, bcd_out=0, bcd_valid=0.
  - Scan counter=0, digit index=0.
  - an_n=3'b110.
  - seg_n=7'b1000000 (displays "0").
- FSM states are IDLE, CONVERT and DONE. busy = (state != IDLE) and is decoded from the state register.
- IDLE:
  - load=1 at edge k: shift register <= result_in, scratch BCD <= 0, iteration count <= 0, go to CONVERT.
  - load=0: stay in IDLE.
- CONVERT, one iteration per clk:
  - Each BCD nibble that is 5 or more gets +3.
  - Then {scratch, shift} is shifted left by 1, so the shift MSB enters the units LSB.
  - After the 8th iteration (edges k+1..k+8), go to DONE.
- DONE (edge k+9):
  - bcd_out <= scratch.
  - bcd_valid <= 1 for exactly one cycle.
  - Go to IDLE.
  - Total latency is 9 clocks from the load edge to bcd_out being visible.
- Boundary and corner cases:
  - load while busy=1 is ignored; there is no queueing.
  - load in the cycle immediately after DONE is accepted normally.
  - result_in is sampled only at the load edge. Later changes have no effect.
  - bcd_out holds its previous value throughout a conversion, so the display never shows intermediate values.
  - Reset mid-conversion aborts it. bcd_out returns to 0, and no bcd_valid pulse is issued.
- Scan:
  - The free-running counter counts 0..REFRESH_DIV-1 and then wraps.
  - On wrap, the digit index advances 0→1→2→0.
  - an_n = ~(3'b001 << index).
  - seg_n is decoded combinationally from the bcd_out nibble selected by the index.
  - Nibble values above 9 cannot occur. If one does, the decoder outputs blank (7'b1111111).
- Scanning runs regardless of FSM state.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - The hundreds digit shows blank (seg_n=7'b1111111) when it is 0.
  - The tens digit shows blank when both hundreds and tens are 0.
  - The units digit is always shown.
  - an_n scanning is unchanged.
- Undefined: all three digits are always displayed, including leading zeros.

Decomposition:
- Package alu_disp_pkg contains:
  - The state enum (IDLE, CONVERT, DONE).
  - SEG_BLANK and the digit 0–9 segment pattern constants.
  - NUM_DIGITS and the BCD nibble width.
- Sub-module bcd_to_seg: a purely combinational 4-bit-to-7-segment decoder, active-low, with blank for values above 9. It is instantiated once on the scan-selected nibble.

Test Plan:
- Reset, then load=1 with result_in=8'd255 → busy=1 from edge 1; at edge 9 bcd_out=12'h255 and bcd_valid pulses for one cycle; busy=0 afterwards.
- result_in=0, then 100, then 9, each loaded after the previous busy falls → bcd_out = 12'h000, 12'h100, 12'h009; bcd_valid pulses exactly three times.
- Load 8'd42; at edge 3 drive load=1 with result_in=8'd200 → the second load is ignored and bcd_out=12'h042 after 9 clocks.
- Load 8'd123; assert rst_n=0 at edge 5 → outputs return to reset values immediately; no bcd_valid pulse; bcd_out=0.
- REFRESH_DIV=4, bcd_out=12'h255 → an_n sequence 110, 101, 011, 110, each held 4 cycles; seg_n = digit-5 pattern, digit-5 pattern, digit-2 pattern.
- LEADING_ZERO_BLANK_EN defined, load 8'd7 → units shows 7, tens and hundreds show 7'b1111111; undefined → tens and hundreds show the digit-0 pattern.
